// File: rtl/debug_pkg.sv
// Debug controller command set, shared by the UART command sequencer and the debug controller.
package debug_pkg;

    typedef enum logic [3:0] {
        PAUSE     = 4'd0,
        RESUME    = 4'd1,
        STEP      = 4'd2,
        RESET     = 4'd3,
        STATUS    = 4'd4,
        BR_PT_ADD = 4'd5,
        BR_PT_RM  = 4'd6,
        MEM_RD    = 4'd7,
        REG_RD    = 4'd8,
        MEM_WR    = 4'd9,
        REG_WR    = 4'd10
    } debug_fn_e;

    localparam logic [7:0] DEFAULT_ACK_BYTE = 8'hA5;
    localparam logic [7:0] DEFAULT_NAK_BYTE = 8'hFF;

    function automatic logic fn_is_valid(input logic [3:0] fn);
        return (fn <= REG_WR);
    endfunction

    function automatic logic fn_has_addr(input logic [3:0] fn);
        logic res;
        case (fn)
            BR_PT_ADD, BR_PT_RM, MEM_RD, REG_RD, MEM_WR, REG_WR: res = 1'b1;
            default:                                             res = 1'b0;
        endcase
        return res;
    endfunction

    function automatic logic fn_has_data(input logic [3:0] fn);
        logic res;
        case (fn)
            MEM_WR, REG_WR: res = 1'b1;
            default:        res = 1'b0;
        endcase
        return res;
    endfunction

    // Number of reply bytes: read-type commands return a full 32-bit word.
    function automatic logic [2:0] fn_reply_len(input logic [3:0] fn);
        logic [2:0] res;
        case (fn)
            STATUS, MEM_RD, REG_RD: res = 3'd4;
            default:                res = 3'd1;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/debug_cmd_sequencer.sv
// Turns UART byte frames into debug controller transactions and streams the reply back.
// Optional inter-byte frame timeout is enabled with `define CMD_TIMEOUT_EN.
module debug_cmd_sequencer
    import debug_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 32'd1_000_000,
    parameter logic [7:0]  ACK_BYTE       = DEFAULT_ACK_BYTE,
    parameter logic [7:0]  NAK_BYTE       = DEFAULT_NAK_BYTE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [3:0]  debug_fn,
    output logic [31:0] addr,
    output logic [31:0] d_in,
    output logic        cmd_valid,
    input  logic        ctrlr_busy,
    input  logic [31:0] d_rd,
    output logic        frame_err,
    output logic        rx_overrun
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RX_ADDR = 3'd1,
        S_RX_DATA = 3'd2,
        S_ISSUE   = 3'd3,
        S_WAIT    = 3'd4,
        S_TX      = 3'd5
    } seq_state_e;

    seq_state_e  state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [1:0]  last_q, last_d;
    logic [3:0]  fn_q, fn_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] din_q, din_d;
    logic [31:0] reply_q, reply_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_valid_q, tx_valid_d;
    logic        cmd_valid_q, cmd_valid_d;
    logic        frame_err_q, frame_err_d;
    logic        overrun_q, overrun_d;
    logic        wait_first_q, wait_first_d;

`ifdef CMD_TIMEOUT_EN
    logic [31:0] tmo_q, tmo_d;
`else
    logic        unused_timeout_s;
    assign unused_timeout_s = (TIMEOUT_CYCLES == 32'd0);
`endif

    // Next-state and output computation for the frame sequencer.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_d       = last_q;
        fn_d         = fn_q;
        addr_d       = addr_q;
        din_d        = din_q;
        reply_d      = reply_q;
        tx_data_d    = tx_data_q;
        tx_valid_d   = tx_valid_q;
        cmd_valid_d  = 1'b0;
        frame_err_d  = 1'b0;
        wait_first_d = 1'b0;
`ifdef CMD_TIMEOUT_EN
        tmo_d        = tmo_q;
`endif

        if (rx_valid && ((state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_TX))) begin
            overrun_d = 1'b1;
        end else begin
            overrun_d = overrun_q;
        end

        case (state_q)
            S_IDLE: begin
                if (rx_valid) begin
                    fn_d  = rx_data[3:0];
                    cnt_d = 2'd0;
                    if (!fn_is_valid(rx_data[3:0])) begin
                        frame_err_d = 1'b1;
                        reply_d     = {NAK_BYTE, 24'h000000};
                        last_d      = 2'd0;
                        tx_data_d   = NAK_BYTE;
                        tx_valid_d  = 1'b1;
                        state_d     = S_TX;
                    end else if (fn_has_addr(rx_data[3:0])) begin
                        state_d = S_RX_ADDR;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RX_ADDR: begin
                if (rx_valid) begin
                    addr_d = {addr_q[23:0], rx_data};
                    if (cnt_q == 2'd3) begin
                        cnt_d   = 2'd0;
                        state_d = fn_has_data(fn_q) ? S_RX_DATA : S_ISSUE;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end else begin
                    addr_d = addr_q;
                end
            end
            S_RX_DATA: begin
                if (rx_valid) begin
                    din_d = {din_q[23:0], rx_data};
                    if (cnt_q == 2'd3) begin
                        cnt_d   = 2'd0;
                        state_d = S_ISSUE;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end else begin
                    din_d = din_q;
                end
            end
            S_ISSUE: begin
                if (!ctrlr_busy) begin
                    cmd_valid_d  = 1'b1;
                    wait_first_d = 1'b1;
                    state_d      = S_WAIT;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_WAIT: begin
                // Busy lags the strobe by a cycle, so the first WAIT cycle cannot signal completion.
                if (!wait_first_q && !ctrlr_busy) begin
                    if (fn_reply_len(fn_q) == 3'd4) begin
                        reply_d = d_rd;
                        last_d  = 2'd3;
                    end else begin
                        reply_d = {ACK_BYTE, 24'h000000};
                        last_d  = 2'd0;
                    end
                    tx_data_d  = reply_d[31:24];
                    tx_valid_d = 1'b1;
                    cnt_d      = 2'd0;
                    state_d    = S_TX;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_TX: begin
                if (tx_valid_q && tx_ready) begin
                    if (cnt_q == last_q) begin
                        tx_valid_d = 1'b0;
                        cnt_d      = 2'd0;
                        state_d    = S_IDLE;
                    end else begin
                        cnt_d     = cnt_q + 2'd1;
                        reply_d   = {reply_q[23:0], 8'h00};
                        tx_data_d = reply_q[23:16];
                    end
                end else begin
                    state_d = S_TX;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef CMD_TIMEOUT_EN
        if (((state_q == S_RX_ADDR) || (state_q == S_RX_DATA)) && !rx_valid) begin
            if (tmo_q >= (TIMEOUT_CYCLES - 32'd1)) begin
                frame_err_d = 1'b1;
                cnt_d       = 2'd0;
                tmo_d       = 32'd0;
                state_d     = S_IDLE;
            end else begin
                tmo_d = tmo_q + 32'd1;
            end
        end else begin
            tmo_d = 32'd0;
        end
`endif
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= 2'd0;
            last_q       <= 2'd0;
            fn_q         <= 4'd0;
            addr_q       <= 32'd0;
            din_q        <= 32'd0;
            reply_q      <= 32'd0;
            tx_data_q    <= 8'd0;
            tx_valid_q   <= 1'b0;
            cmd_valid_q  <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            wait_first_q <= 1'b0;
`ifdef CMD_TIMEOUT_EN
            tmo_q        <= 32'd0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_q       <= last_d;
            fn_q         <= fn_d;
            addr_q       <= addr_d;
            din_q        <= din_d;
            reply_q      <= reply_d;
            tx_data_q    <= tx_data_d;
            tx_valid_q   <= tx_valid_d;
            cmd_valid_q  <= cmd_valid_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
            wait_first_q <= wait_first_d;
`ifdef CMD_TIMEOUT_EN
            tmo_q        <= tmo_d;
`endif
        end
    end

    assign tx_data    = tx_data_q;
    assign tx_valid   = tx_valid_q;
    assign debug_fn   = fn_q;
    assign addr       = addr_q;
    assign d_in       = din_q;
    assign cmd_valid  = cmd_valid_q;
    assign frame_err  = frame_err_q;
    assign rx_overrun = overrun_q;

endmodule

// File: tb/tb_debug_cmd_sequencer.sv
// Randomized self-checking bench for debug_cmd_sequencer; timeout scenario follows CMD_TIMEOUT_EN.
module tb_debug_cmd_sequencer;

    typedef logic [7:0] byte_q_t[$];

    logic        clk;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [3:0]  debug_fn;
    logic [31:0] addr;
    logic [31:0] d_in;
    logic        cmd_valid;
    logic        ctrlr_busy;
    logic [31:0] d_rd;
    logic        frame_err;
    logic        rx_overrun;

    int tests_run    = 0;
    int tests_failed = 0;

    // Stimulus knobs owned by the main thread and read by the responders.
    logic [31:0] rd_value;
    int          busy_len;
    int          ready_mode;
    bit          spurious_en;

    // Observations owned by the responders/monitors.
    logic [7:0]  obs_tx[$];
    logic [3:0]  cmd_fn_q[$];
    logic [31:0] cmd_addr_q[$];
    logic [31:0] cmd_din_q[$];
    int          ferr_cnt = 0;

    // Reference model state.
    logic [31:0] exp_addr;
    logic [31:0] exp_din;
    bit          exp_overrun;

    debug_cmd_sequencer #(
        .TIMEOUT_CYCLES(100),
        .ACK_BYTE      (8'hA5),
        .NAK_BYTE      (8'hFF)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .debug_fn  (debug_fn),
        .addr      (addr),
        .d_in      (d_in),
        .cmd_valid (cmd_valid),
        .ctrlr_busy(ctrlr_busy),
        .d_rd      (d_rd),
        .frame_err (frame_err),
        .rx_overrun(rx_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Debug controller: busy rises a cycle after the strobe, random spurious busy when idle.
    initial begin
        ctrlr_busy = 1'b0;
        d_rd       = 32'h0;
        forever begin
            @(negedge clk);
            if (cmd_valid) begin
                check_value("issue_while_busy", 32'(ctrlr_busy), 32'd0);
                cmd_fn_q.push_back(debug_fn);
                cmd_addr_q.push_back(addr);
                cmd_din_q.push_back(d_in);
                @(negedge clk);
                check_value("cmd_pulse_width", 32'(cmd_valid), 32'd0);
                ctrlr_busy = 1'b1;
                d_rd       = $urandom();
                repeat (busy_len) @(negedge clk);
                d_rd       = rd_value;
                ctrlr_busy = 1'b0;
            end else if (spurious_en && ($urandom_range(0, 7) == 0)) begin
                ctrlr_busy = 1'b1;
                repeat ($urandom_range(1, 4)) @(negedge clk);
                ctrlr_busy = 1'b0;
            end
        end
    end

    // UART TX sink: collects accepted bytes and checks the hold-until-accepted rule.
    initial begin
        bit         prev_valid;
        bit         prev_ready;
        logic [7:0] prev_data;
        bit         rdy;
        int         hold;
        prev_valid = 1'b0;
        prev_ready = 1'b0;
        prev_data  = 8'h00;
        hold       = 0;
        tx_ready   = 1'b0;
        forever begin
            @(negedge clk);
            if (prev_valid && !prev_ready) begin
                check_value("tx_valid_hold", 32'(tx_valid), 32'd1);
                check_value("tx_data_hold", 32'(tx_data), 32'(prev_data));
            end
            if (ready_mode == 2)      rdy = (hold >= 10);
            else if (ready_mode == 1) rdy = 1'b1;
            else                      rdy = ($urandom_range(0, 1) == 1);
            tx_ready = rdy;
            if (tx_valid && rdy) begin
                obs_tx.push_back(tx_data);
                hold = 0;
            end else if (tx_valid) begin
                hold++;
            end else begin
                hold = 0;
            end
            prev_valid = tx_valid;
            prev_ready = rdy;
            prev_data  = tx_data;
        end
    end

    // frame_err monitor.
    initial begin
        bit prev_ferr;
        prev_ferr = 1'b0;
        forever begin
            @(negedge clk);
            if (frame_err) begin
                check_value("frame_err_pulse", 32'(prev_ferr), 32'd0);
                ferr_cnt++;
            end
            prev_ferr = frame_err;
        end
    end

    task automatic check_idle_outputs(input string tag);
        check_value({tag, "_tx_valid"}, 32'(tx_valid), 32'd0);
        check_value({tag, "_tx_data"}, 32'(tx_data), 32'd0);
        check_value({tag, "_cmd_valid"}, 32'(cmd_valid), 32'd0);
        check_value({tag, "_debug_fn"}, 32'(debug_fn), 32'd0);
        check_value({tag, "_addr"}, addr, 32'd0);
        check_value({tag, "_d_in"}, d_in, 32'd0);
        check_value({tag, "_frame_err"}, 32'(frame_err), 32'd0);
        check_value({tag, "_rx_overrun"}, 32'(rx_overrun), 32'd0);
    endtask

    // Send one complete frame and compare the transaction and reply against the model.
    task automatic run_frame(input byte_q_t fr, input int gap_max, input int stall_at,
                             input int stall_len, input bit stray);
        logic [3:0] fn;
        bit         ok;
        byte_q_t    exp_tx;
        int         obs_base;
        int         cmd_base;
        int         ferr_base;
        fn        = fr[0][3:0];
        ok        = (fn <= 4'd10);
        obs_base  = obs_tx.size();
        cmd_base  = cmd_fn_q.size();
        ferr_base = ferr_cnt;
        if (!ok) begin
            exp_tx.push_back(8'hFF);
        end else if ((fn == 4'd4) || (fn == 4'd7) || (fn == 4'd8)) begin
            for (int k = 3; k >= 0; k--) exp_tx.push_back(rd_value[8*k +: 8]);
        end else begin
            exp_tx.push_back(8'hA5);
        end
        if (ok && (fn >= 4'd5)) exp_addr = {fr[1], fr[2], fr[3], fr[4]};
        if (ok && (fn >= 4'd9)) exp_din  = {fr[5], fr[6], fr[7], fr[8]};

        foreach (fr[i]) begin
            rx_data  = fr[i];
            rx_valid = 1'b1;
            @(negedge clk);
            rx_valid = 1'b0;
            if (i == stall_at) repeat (stall_len) @(negedge clk);
            repeat ($urandom_range(0, gap_max)) @(negedge clk);
        end
        if (stray) begin
            repeat (2) @(negedge clk);
            rx_data  = 8'h5A;
            rx_valid = 1'b1;
            @(negedge clk);
            rx_valid    = 1'b0;
            exp_overrun = 1'b1;
        end

        for (int c = 0; (c < 3000) && ((obs_tx.size() - obs_base) < exp_tx.size()); c++)
            @(negedge clk);
        repeat (4) @(negedge clk);

        check_value("reply_len", 32'(obs_tx.size() - obs_base), 32'(exp_tx.size()));
        foreach (exp_tx[k]) begin
            if ((obs_base + k) < obs_tx.size())
                check_value("reply_byte", 32'(obs_tx[obs_base + k]), 32'(exp_tx[k]));
        end
        check_value("cmd_count", 32'(cmd_fn_q.size() - cmd_base), ok ? 32'd1 : 32'd0);
        check_value("frame_err_count", 32'(ferr_cnt - ferr_base), ok ? 32'd0 : 32'd1);
        if (ok && (cmd_fn_q.size() > cmd_base)) begin
            check_value("cmd_fn", 32'(cmd_fn_q[cmd_base]), 32'(fn));
            check_value("cmd_addr", cmd_addr_q[cmd_base], exp_addr);
            check_value("cmd_d_in", cmd_din_q[cmd_base], exp_din);
        end
        if (ok) begin
            check_value("hold_debug_fn", 32'(debug_fn), 32'(fn));
            check_value("hold_addr", addr, exp_addr);
            check_value("hold_d_in", d_in, exp_din);
        end
        check_value("rx_overrun", 32'(rx_overrun), 32'(exp_overrun));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, required finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        byte_q_t    fr;
        logic [3:0] lo;
        int         cmd_base;
        int         obs_base;
        int         ferr_base;
        bit         seen;
        int         seen_at;

        reset       = 1'b1;
        rx_valid    = 1'b0;
        rx_data     = 8'h00;
        rd_value    = 32'h0;
        busy_len    = 2;
        ready_mode  = 1;
        spurious_en = 1'b0;
        exp_addr    = 32'h0;
        exp_din     = 32'h0;
        exp_overrun = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        reset = 1'b0;
        @(negedge clk);

        // PAUSE, no operands.
        rd_value = 32'h13579BDF;
        fr = {8'h00};
        run_frame(fr, 0, -1, 0, 1'b0);

        // MEM_RD with four reply bytes, controller sometimes busy before issue.
        spurious_en = 1'b1;
        rd_value    = 32'hDEADBEEF;
        busy_len    = 3;
        fr = {8'h07, 8'h00, 8'h00, 8'h10, 8'h04};
        run_frame(fr, 0, -1, 0, 1'b0);

        // REG_WR with receiver stalled for ten cycles.
        ready_mode = 2;
        fr = {8'h0A, 8'h00, 8'h00, 8'h00, 8'h05, 8'h12, 8'h34, 8'h56, 8'h78};
        run_frame(fr, 1, -1, 0, 1'b0);
        ready_mode = 1;

        // Invalid opcode, then a stray byte while a read is outstanding.
        fr = {8'h0C};
        run_frame(fr, 0, -1, 0, 1'b0);
        busy_len = 20;
        rd_value = 32'hCAFE0123;
        fr = {8'h38, 8'hAB, 8'hCD, 8'hEF, 8'h01};
        run_frame(fr, 0, -1, 0, 1'b1);
        busy_len = 2;

`ifdef CMD_TIMEOUT_EN
        cmd_base  = cmd_fn_q.size();
        obs_base  = obs_tx.size();
        ferr_base = ferr_cnt;
        fr = {8'h05, 8'h00, 8'h00};
        foreach (fr[k]) begin
            rx_data  = fr[k];
            rx_valid = 1'b1;
            @(negedge clk);
        end
        rx_valid = 1'b0;
        seen     = 1'b0;
        seen_at  = 0;
        for (int c = 1; (c <= 150) && !seen; c++) begin
            @(negedge clk);
            if (frame_err) begin
                seen    = 1'b1;
                seen_at = c;
            end
        end
        check_value("timeout_fired", 32'(seen), 32'd1);
        check_value("timeout_window", 32'((seen_at >= 98) && (seen_at <= 102)), 32'd1);
        repeat (5) @(negedge clk);
        check_value("timeout_no_reply", 32'(obs_tx.size() - obs_base), 32'd0);
        check_value("timeout_no_cmd", 32'(cmd_fn_q.size() - cmd_base), 32'd0);
        check_value("timeout_ferr_count", 32'(ferr_cnt - ferr_base), 32'd1);
        exp_addr = {exp_addr[15:0], 16'h0000};
        fr = {8'h02};
        run_frame(fr, 0, -1, 0, 1'b0);
`else
        fr = {8'h05, 8'h00, 8'h00, 8'h12, 8'h34};
        run_frame(fr, 0, 2, 150, 1'b0);
`endif

        // Reset after the third byte of a MEM_WR frame.
        cmd_base = cmd_fn_q.size();
        fr = {8'h09, 8'h11, 8'h22};
        foreach (fr[k]) begin
            rx_data  = fr[k];
            rx_valid = 1'b1;
            @(negedge clk);
        end
        rx_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        check_idle_outputs("midframe_reset");
        reset       = 1'b0;
        exp_addr    = 32'h0;
        exp_din     = 32'h0;
        exp_overrun = 1'b0;
        repeat (20) @(negedge clk);
        check_value("reset_no_cmd", 32'(cmd_fn_q.size() - cmd_base), 32'd0);
        fr = {8'h01};
        run_frame(fr, 0, -1, 0, 1'b0);

        // Random frames.
        for (int f = 0; f < 40; f++) begin
            lo = 4'($urandom_range(0, 15));
            fr.delete();
            fr.push_back({4'($urandom_range(0, 15)), lo});
            if ((lo >= 4'd5) && (lo <= 4'd10)) repeat (4) fr.push_back(8'($urandom()));
            if ((lo == 4'd9) || (lo == 4'd10)) repeat (4) fr.push_back(8'($urandom()));
            rd_value   = $urandom();
            busy_len   = $urandom_range(1, 6);
            ready_mode = $urandom_range(0, 1);
            run_frame(fr, $urandom_range(0, 2), -1, 0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
